sem_phase_sched: RTL and testbench
==================================

Name: sem_phase_sched

Overview:
- Traffic-light phase scheduler for one crossing: car lamps, one pedestrian WALK lamp, and a pedestrian request/acknowledge handshake.
- Owns an internal prescaler that divides `clk` into a one-cycle `tick` enable; all phase timing is counted in ticks.
- Sequences GREEN -> YELLOW -> RED -> (WALK) -> GREEN with per-phase durations set by parameters.
- Single clock domain; `tick` is exported so other logic on the crossing shares the same timebase.

Parameters:
- TICK_DIV, 10, clk cycles per tick; must be >= 2.
- T_GREEN, 8, GREEN phase length in ticks; must be >= 1.
- T_YELLOW, 2, YELLOW phase length in ticks; must be >= 1.
- T_RED, 6, RED phase length in ticks; must be >= 1.
- T_PED, 5, WALK phase length in ticks; must be >= 1.
- CNT_W, 8, width of the phase countdown; must hold max(T_*)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  timebase enable; low freezes prescaler and phase timing.
- ped_req  in  1  pedestrian request level; held high by requester until ped_ack.
- ped_ack  out  1  one-cycle pulse when WALK is entered.
- tick  out  1  one-cycle timebase pulse.
- phase  out  2  current phase: 0 GREEN, 1 YELLOW, 2 RED, 3 WALK.
- remaining  out  CNT_W  ticks left in current phase minus 1.
- car_green  out  1  car green lamp.
- car_yellow  out  1  car yellow lamp.
- car_red  out  1  car red lamp.
- ped_walk  out  1  pedestrian WALK lamp.

Behaviour:
- Reset (rst low, async):
  - phase=GREEN, remaining=T_GREEN-1, prescaler=0, ped_pend=0, ped_ack=0.
  - Lamps: car_green=1, all other lamps 0.
  - Applies immediately, including mid-phase or mid-WALK.
- Prescaler:
  - Width clog2(TICK_DIV); counts 0..TICK_DIV-1 then wraps to 0, only while en=1.
  - tick = en AND (prescaler == TICK_DIV-1); combinational, high for exactly one cycle per TICK_DIV enabled cycles.
- en=0: prescaler, phase, remaining and ped_ack hold; tick=0; ped_pend still captures requests.
- Phase countdown:
  - On a tick with remaining>0: remaining decrements.
  - On a tick with remaining==0: phase advances and remaining loads T_next-1.
  - Each phase therefore lasts exactly T_x*TICK_DIV clocks with en held high.
- Phase transitions, evaluated only on a tick with remaining==0:
  - GREEN -> YELLOW.
  - YELLOW -> RED.
  - RED -> WALK if (ped_pend OR ped_req), else RED -> GREEN.
  - WALK -> GREEN.
- Lamp decode (Moore, from phase register only):
  - GREEN: car_green=1.
  - YELLOW: car_yellow=1.
  - RED: car_red=1.
  - WALK: car_red=1 and ped_walk=1.
- Pedestrian handshake:
  - ped_pend sets on any cycle with ped_req=1 while phase!=WALK.
  - ped_pend clears on the edge entering WALK; clear dominates set.
  - ped_ack is a registered pulse, high for the single cycle after the entering-WALK edge.
  - ped_req while phase==WALK is ignored. If still high once GREEN is entered, it is captured as a new request.
  - A request asserted on the same cycle as RED expiry is served (direct ped_req term in the transition).
  - Dropping ped_req before ack does not cancel a captured request.
- remaining saturates at no value: it never underflows because the load happens at 0.
- Width rule: T_x-1 is truncated to CNT_W. The parameter constraint forbids overflow; a violation is a configuration error and needs no runtime check.

Test Plan:
Common setup: TICK_DIV=4, T_GREEN=3, T_YELLOW=2, T_RED=2, T_PED=2, en=1, rst released at cycle 0.
1. No requests -> GREEN 12 clks, YELLOW 8, RED 8, GREEN again at clk 28; tick every 4th clk; lamps one-hot per phase.
2. ped_req high from clk 5 until ped_ack -> G->Y->R, then WALK at clk 28. ped_ack high clk 28 only; car_red=ped_walk=1 for 8 clks; GREEN at clk 36.
3. ped_req pulsed for exactly clk 27 only (RED final-tick cycle) -> WALK entered at clk 28; ped_pend=0 afterward.
4. en=0 for 10 clks starting mid-YELLOW (remaining=1) -> phase, remaining and prescaler frozen, tick=0; YELLOW resumes and ends 10 clks late.
5. rst low mid-WALK -> same cycle: phase=GREEN, remaining=2, ped_walk=0, ped_ack=0, ped_pend=0; after release a normal 12-clk GREEN follows.
6. ped_req raised during WALK and held -> not acked in that WALK; captured in next GREEN; second WALK follows the next RED; exactly one ped_ack per WALK.

Source files
------------

// File: rtl/sem_phase_sched.sv
// rtl/sem_phase_sched.sv - traffic-light phase scheduler with internal tick prescaler
module sem_phase_sched #(
  parameter int TICK_DIV = 10,
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 2,
  parameter int T_RED    = 6,
  parameter int T_PED    = 5,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ped_req,
  output logic             ped_ack,
  output logic             tick,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             car_green,
  output logic             car_yellow,
  output logic             car_red,
  output logic             ped_walk
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_MAX   = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] R_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] R_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] R_RED    = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] R_PED    = CNT_W'(T_PED - 1);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_RED    = 2'd2,
    PH_WALK   = 2'd3
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             tick_w;
  logic             enter_walk;

  always_comb begin
    tick_w     = en && (ps_q == PS_MAX);
    ps_d       = ps_q;
    phase_d    = phase_q;
    rem_d      = rem_q;
    enter_walk = 1'b0;

    if (en) begin
      ps_d = tick_w ? '0 : ps_q + 1'b1;
    end

    // Phases only move on a tick whose countdown has already reached zero.
    if (tick_w) begin
      if (rem_q != '0) begin
        rem_d = rem_q - 1'b1;
      end else begin
        case (phase_q)
          PH_GREEN: begin
            phase_d = PH_YELLOW;
            rem_d   = R_YELLOW;
          end
          PH_YELLOW: begin
            phase_d = PH_RED;
            rem_d   = R_RED;
          end
          PH_RED: begin
            if (pend_q || ped_req) begin
              phase_d    = PH_WALK;
              rem_d      = R_PED;
              enter_walk = 1'b1;
            end else begin
              phase_d = PH_GREEN;
              rem_d   = R_GREEN;
            end
          end
          default: begin
            phase_d = PH_GREEN;
            rem_d   = R_GREEN;
          end
        endcase
      end
    end

    // Entering WALK consumes the pending request even if ped_req is still high.
    pend_d = pend_q | (ped_req && (phase_q != PH_WALK));
    if (enter_walk) begin
      pend_d = 1'b0;
    end
    ack_d = en ? enter_walk : ack_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_GREEN;
      rem_q   <= R_GREEN;
      ps_q    <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      ps_q    <= ps_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  assign tick       = tick_w;
  assign phase      = phase_q;
  assign remaining  = rem_q;
  assign ped_ack    = ack_q;
  assign car_green  = (phase_q == PH_GREEN);
  assign car_yellow = (phase_q == PH_YELLOW);
  assign car_red    = (phase_q == PH_RED) || (phase_q == PH_WALK);
  assign ped_walk   = (phase_q == PH_WALK);

endmodule

// File: tb/tb_sem_phase_sched.sv
// tb/tb_sem_phase_sched.sv - directed and random checks of sem_phase_sched against a timeline model
module tb_sem_phase_sched;

  localparam int TD    = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             ped_req = 1'b0;
  logic             ped_ack, tick, car_green, car_yellow, car_red, ped_walk;
  logic [1:0]       phase;
  logic [CNT_W-1:0] remaining;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: current phase and number of enabled clocks already spent in it.
  int m_phase, m_el, m_acks;
  bit m_pend, m_ack;

  sem_phase_sched #(
    .TICK_DIV(TD), .T_GREEN(3), .T_YELLOW(2), .T_RED(2), .T_PED(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .ped_ack(ped_ack), .tick(tick),
    .phase(phase), .remaining(remaining), .car_green(car_green), .car_yellow(car_yellow),
    .car_red(car_red), .ped_walk(ped_walk)
  );

  always #5 clk = ~clk;

  function automatic int dur_clks(input int p);
    case (p)
      0: return 3 * TD;
      1: return 2 * TD;
      2: return 2 * TD;
      default: return 2 * TD;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_el    = 0;
    m_pend  = 0;
    m_ack   = 0;
  endtask

  task automatic model_step(input bit e, input bit r);
    int  nxt;
    bit  ew;
    bit  set_req;
    set_req = r && (m_phase != 3);
    if (!e) begin
      if (set_req) m_pend = 1;
      return;
    end
    ew = 0;
    if (m_el == dur_clks(m_phase) - 1) begin
      if (m_phase == 2) nxt = (m_pend || r) ? 3 : 0;
      else if (m_phase == 3) nxt = 0;
      else nxt = m_phase + 1;
      ew = (nxt == 3);
      m_phase = nxt;
      m_el = 0;
    end else begin
      m_el++;
    end
    if (ew) m_pend = 0;
    else if (set_req) m_pend = 1;
    m_ack = ew;
    if (ew) m_acks++;
  endtask

  task automatic check_all();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("remaining", 32'(remaining), 32'((dur_clks(m_phase) - 1 - m_el) / TD));
    chk("tick", 32'(tick), 32'(en && (m_el % TD == TD - 1)));
    chk("ped_ack", 32'(ped_ack), 32'(m_ack));
    chk("car_green", 32'(car_green), 32'(m_phase == 0));
    chk("car_yellow", 32'(car_yellow), 32'(m_phase == 1));
    chk("car_red", 32'(car_red), 32'(m_phase >= 2));
    chk("ped_walk", 32'(ped_walk), 32'(m_phase == 3));
  endtask

  task automatic step(input bit e, input bit r);
    en = e;
    ped_req = r;
    @(posedge clk);
    model_step(e, r);
    @(negedge clk);
    check_all();
  endtask

  // Assert reset mid-cycle, check its immediate effect, release on a falling edge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    m_acks = 0;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    bit req_h;
    int  hold;
    model_reset();
    m_acks = 0;

    // Test 1: no requests
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      step(1, 0);
      if (i == 12) chk("t1_yellow_at_12", 32'(phase), 32'd1);
      if (i == 20) chk("t1_red_at_20", 32'(phase), 32'd2);
    end
    chk("t1_green_at_28", 32'(phase), 32'd0);

    // Test 2: request held from clk 5 until ack
    do_reset();
    req_h = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 6) req_h = 1;
      step(1, req_h);
      if (m_ack) req_h = 0;
      if (i == 28) begin
        chk("t2_walk_at_28", 32'(phase), 32'd3);
        chk("t2_ack_at_28", 32'(ped_ack), 32'd1);
      end
      if (i == 29) chk("t2_ack_low_29", 32'(ped_ack), 32'd0);
      if (i == 36) chk("t2_green_at_36", 32'(phase), 32'd0);
    end

    // Test 3: one-cycle request on RED's final tick cycle
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      step(1, i == 28);
      if (i == 28) chk("t3_walk_at_28", 32'(phase), 32'd3);
    end
    chk("t3_no_second_walk", 32'(phase), 32'd0);
    chk("t3_one_ack", 32'(m_acks), 32'd1);

    // Test 4: en low for 10 clks mid-YELLOW
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(!(i >= 15 && i <= 24), 0);
      if (i == 14) chk("t4_rem_before_freeze", 32'(remaining), 32'd1);
      if (i == 24) chk("t4_rem_frozen", 32'(remaining), 32'd1);
      if (i == 29) chk("t4_yellow_late", 32'(phase), 32'd1);
      if (i == 30) chk("t4_red_at_30", 32'(phase), 32'd2);
    end

    // Test 5: reset mid-WALK
    do_reset();
    for (int i = 1; i <= 31; i++) step(1, i >= 6 && i < 28);
    chk("t5_in_walk", 32'(ped_walk), 32'd1);
    do_reset();
    chk("t5_rem_after_rst", 32'(remaining), 32'd2);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0);
      if (i == 11) chk("t5_green_11", 32'(phase), 32'd0);
    end
    chk("t5_yellow_12", 32'(phase), 32'd1);

    // Test 6: request raised during WALK waits for the next cycle
    do_reset();
    req_h = 0;
    for (int i = 1; i <= 72; i++) begin
      if (i == 6 || i == 30) req_h = 1;
      step(1, req_h);
      if (m_ack) req_h = 0;
      if (i == 36) chk("t6_one_ack_first_walk", 32'(m_acks), 32'd1);
      if (i == 64) chk("t6_second_ack_64", 32'(ped_ack), 32'd1);
    end
    chk("t6_two_acks", 32'(m_acks), 32'd2);

    // Random: en mostly high, requester holds until ack or occasionally gives up
    do_reset();
    req_h = 0;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!req_h && ($urandom % 20 == 0)) req_h = 1;
      else if (req_h && ($urandom % 40 == 0)) req_h = 0;
      step(($urandom % 8) != 0, req_h);
      if (m_ack) req_h = 0;
      if (i == 1500) begin
        do_reset();
        req_h = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
